// File: rtl/mvm_seq_sat.sv
// Time-multiplexed signed fixed-point matrix-vector multiplier: c = A*b, one column of A per clock
// across H parallel MAC lanes, followed by rescale (floor or round-half-up) and saturation to DATA_WIDTH.
module mvm_seq_sat #(
  parameter int X          = 4,
  parameter int H          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int ROUND      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [0:X*H*DATA_WIDTH-1]     a_in,
  input  logic [0:X*DATA_WIDTH-1]       b_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [0:H*DATA_WIDTH-1]       c_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [1:0]                    state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid/ready seen at any other time carry no meaning. in_ready is high only in IDLE,
  // out_valid only in DONE, so accepting and delivering never overlap.

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + $clog2(X) + 1;
  localparam int CW = (X > 1) ? $clog2(X) : 1;

  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] RND  = (ROUND != 0) ? (AW'(1) << (FRAC_BITS - 1)) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [0:X*H*DW-1]       a_q, a_d;
  logic [0:X*DW-1]         b_q, b_d;
  logic [CW-1:0]           col_q, col_d;
  logic [0:H*DW-1]         c_q, c_d;
  logic signed [AW-1:0]    acc_q [H];
  logic signed [AW-1:0]    acc_d [H];
  logic signed [PW-1:0]    prod  [H];

  function automatic logic [DW-1:0] rescale_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    r = (v + RND) >>> FRAC_BITS;
    if (r > SMAX)      rescale_sat = SMAX[DW-1:0];
    else if (r < SMIN) rescale_sat = SMIN[DW-1:0];
    else               rescale_sat = r[DW-1:0];
  endfunction

  // One exact DW x DW product per lane for the current column.
  always_comb begin
    for (int m = 0; m < H; m++) begin
      prod[m] = PW'($signed(a_q[((m * X) + int'(col_q)) * DW +: DW]))
              * PW'($signed(b_q[int'(col_q) * DW +: DW]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    col_d   = col_q;
    c_d     = c_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          col_d   = '0;
          for (int m = 0; m < H; m++) acc_d[m] = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        for (int m = 0; m < H; m++) acc_d[m] = acc_q[m] + AW'(prod[m]);
        col_d = col_q + CW'(1);
        if (col_q == CW'(X - 1)) begin
          col_d = '0;
          for (int m = 0; m < H; m++) c_d[m * DW +: DW] = rescale_sat(acc_d[m]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      col_q   <= '0;
      c_q     <= '0;
      for (int m = 0; m < H; m++) acc_q[m] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      col_q   <= col_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MAC);
  assign out_valid = (state_q == S_DONE);
  assign c_out     = c_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mvm_seq_sat.sv
// Bench for mvm_seq_sat: truncating and rounding 4x4 instances share stimulus, plus an X=1 instance;
// results are compared against an integer dot-product model through a scoreboard queue.
module tb_mvm_seq_sat;

  localparam int X  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int FB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [0:X*H*DW-1] a_in;
  logic [0:X*DW-1]   b_in;
  logic              in_valid, out_ready;
  logic              in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [0:H*DW-1]   c0, c1;
  logic [1:0]        st0, st1;

  logic [0:2*DW-1]   a2;
  logic [0:DW-1]     b2;
  logic              in_valid2, out_ready2, in_ready2, out_valid2, busy2;
  logic [0:2*DW-1]   c2;
  logic [1:0]        st2;

  mvm_seq_sat #(.X(X), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready0),
    .c_out(c0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0), .state_o(st0));

  mvm_seq_sat #(.X(X), .H(H), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready1),
    .c_out(c1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .state_o(st1));

  mvm_seq_sat #(.X(1), .H(2), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROUND(1)) u_x1 (
    .clk(clk), .rst(rst), .a_in(a2), .b_in(b2), .in_valid(in_valid2), .in_ready(in_ready2),
    .c_out(c2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .state_o(st2));

  int A [H][X];
  int bv [X];
  logic [H*DW-1:0] exp_q0[$];
  logic [H*DW-1:0] exp_q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: exact integer dot product, then rescale and clamp
  function automatic int sat_scale(input int s, input int rnd);
    int r;
    r = (rnd != 0) ? s + (1 << (FB - 1)) : s;
    r = r >>> FB;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic logic [0:H*DW-1] ref_main(input int rnd);
    logic [0:H*DW-1] v;
    int s;
    for (int m = 0; m < H; m++) begin
      s = 0;
      for (int n = 0; n < X; n++) s += A[m][n] * bv[n];
      v[m*DW +: DW] = DW'(sat_scale(s, rnd));
    end
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_main();
    for (int m = 0; m < H; m++)
      for (int n = 0; n < X; n++) a_in[((m*X)+n)*DW +: DW] = DW'(A[m][n]);
    for (int n = 0; n < X; n++) b_in[n*DW +: DW] = DW'(bv[n]);
  endtask

  task automatic fill_job(input int av, input int bval);
    for (int m = 0; m < H; m++)
      for (int n = 0; n < X; n++) A[m][n] = av;
    for (int n = 0; n < X; n++) bv[n] = bval;
    pack_main();
  endtask

  task automatic rand_job();
    for (int m = 0; m < H; m++)
      for (int n = 0; n < X; n++) A[m][n] = int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < X; n++) bv[n] = int'($urandom_range(0, 255)) - 128;
    pack_main();
  endtask

  task automatic accept_job();
    check("in_ready_idle", in_ready0, 1);
    exp_q0.push_back(ref_main(0));
    exp_q1.push_back(ref_main(1));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_mac", busy0, 1);
    check("in_ready_mac", in_ready0, 0);
    // input changes after acceptance must not reach the running job
    for (int i = 0; i < X*H; i++) a_in[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < X; i++) b_in[i*DW +: DW] = DW'($urandom);
  endtask

  // out_valid must first be sampled high at edge X+1 after the accept edge
  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    check("latency_edge", n + 1, X + 1);
    check("round_inst_valid", out_valid1, 1);
  endtask

  task automatic consume();
    logic [H*DW-1:0] e0, e1;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    out_ready = 1'b1;
    check("c_trunc", c0, e0);
    check("c_round", c1, e1);
    tick();
    out_ready = 1'b0;
    check("idle_after_done", out_valid0, 0);
    check("in_ready_after_done", in_ready0, 1);
    check("c_held_in_idle", c0, e0);
  endtask

  task automatic run_x1();
    int a2v [2];
    int bb, n;
    logic [0:2*DW-1] e;
    for (int m = 0; m < 2; m++) a2v[m] = int'($urandom_range(0, 255)) - 128;
    bb = int'($urandom_range(0, 255)) - 128;
    for (int m = 0; m < 2; m++) begin
      a2[m*DW +: DW] = DW'(a2v[m]);
      e[m*DW +: DW]  = DW'(sat_scale(a2v[m] * bb, 1));
    end
    b2 = DW'(bb);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 10) begin
      tick();
      n++;
    end
    check("x1_latency_edge", n + 1, 2);
    check("x1_c", c2, e);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("x1_in_ready", in_ready2, 1);
  endtask

  initial begin
    logic seen;
    int accepted, got, last_t, cyc, hold;
    logic acc_now;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_c", c0, 0);
    check("rst_c_round", c1, 0);
    check("rst_x1_in_ready", in_ready2, 1);

    // identity
    fill_job(0, 0);
    for (int i = 0; i < X; i++) A[i][i] = 16;
    bv[0] = 32; bv[1] = -48; bv[2] = 5; bv[3] = 127;
    pack_main();
    accept_job(); wait_out();
    check("ident_lit", c0, 32'h20D0_057F);
    consume();

    // saturation both ways
    fill_job(127, 127);
    accept_job(); wait_out();
    check("sat_pos_lit", c0, 32'h7F7F_7F7F);
    consume();
    fill_job(-128, 127);
    accept_job(); wait_out();
    check("sat_neg_lit", c1, 32'h8080_8080);
    consume();

    // rounding
    fill_job(0, 0); A[0][0] = 1; bv[0] = -1; pack_main();
    accept_job(); wait_out();
    check("rnd_floor_lit", c0, 32'hFF00_0000);
    check("rnd_half_lit", c1, 32'h0000_0000);
    consume();
    fill_job(0, 0); A[0][0] = 8; bv[0] = 1; pack_main();
    accept_job(); wait_out();
    check("rnd_up_lit", c1, 32'h0100_0000);
    consume();

    // backpressure with a competing job waiting
    rand_job();
    accept_job(); wait_out();
    rand_job();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_c_stable", c0, exp_q0[0]);
      check("bp_in_ready", in_ready0, 0);
      check("bp_out_valid", out_valid0, 1);
      tick();
    end
    consume();
    accept_job(); wait_out(); consume();

    // reset in the middle of MAC
    rand_job();
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_in_ready", in_ready0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_c", c0, 0);
    check("mid_rst_c_round", c1, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | out_valid0 | out_valid1;
      tick();
    end
    check("mid_rst_no_out", seen, 0);
    rand_job();
    accept_job(); wait_out(); consume();

    // random jobs with random downstream stalls
    for (int j = 0; j < 6; j++) begin
      rand_job();
      accept_job(); wait_out();
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        check("rand_hold", c0, exp_q0[0]);
        tick();
      end
      consume();
    end

    // back-to-back with both handshakes held high
    rand_job();
    in_valid = 1'b1; out_ready = 1'b1;
    accepted = 0; got = 0; last_t = 0; cyc = 0;
    while (got < 3 && cyc < 80) begin
      acc_now = in_valid && in_ready0;
      if (acc_now) begin
        exp_q0.push_back(ref_main(0));
        exp_q1.push_back(ref_main(1));
      end
      if (out_valid0) begin
        if (exp_q0.size() == 0) check("b2b_scoreboard", 1, 0);
        else begin
          check("b2b_c_trunc", c0, exp_q0.pop_front());
          check("b2b_c_round", c1, exp_q1.pop_front());
        end
        if (got > 0) check("b2b_gap", cyc - last_t, X + 2);
        last_t = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        accepted++;
        if (accepted == 3) in_valid = 1'b0;
        else rand_job();
      end
    end
    out_ready = 1'b0;
    check("b2b_count", got, 3);

    // single-column instance
    for (int j = 0; j < 4; j++) run_x1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
